// File: rtl/raw_readback_pkg.sv
// rtl/raw_readback_pkg.sv - shared state encodings and MCB field widths for the raw-data path
package raw_readback_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } rb_state_t;

    localparam int DEF_FBITS = 2;
    localparam int MCB_ABITS = 20;
    localparam int MCB_DBITS = 32;

endpackage

// File: rtl/readback_fifo.sv
// rtl/readback_fifo.sv - first-word-fall-through sample FIFO with flush, distributed-RAM storage
module readback_fifo
    import raw_readback_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int FBITS = DEF_FBITS
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic [FBITS:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [FBITS:0] DEPTH = (FBITS+1)'(2**FBITS);

    logic [WIDTH-1:0] mem [2**FBITS];
    logic [FBITS-1:0] wr_ptr;
    logic [FBITS-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head word is read asynchronously; forced to zero while empty so reset leaves data at 0.
    assign data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FBITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FBITS'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (FBITS+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (FBITS+1)'(1);
            end
        end
    end

endmodule

// File: rtl/raw_readback.sv
// rtl/raw_readback.sv - sequential SDRAM readback through the MCB read port into a credit-limited FIFO
module raw_readback
    import raw_readback_pkg::*;
#(
    parameter int AXNUM = 24,
    parameter int ABITS = MCB_ABITS,
    parameter int FBITS = DEF_FBITS
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic [ABITS-1:0]     length_i,
    output logic                 mcb_ce_o,
    output logic                 mcb_wr_o,
    input  logic                 mcb_rdy_i,
    output logic [ABITS-1:0]     mcb_adr_o,
    input  logic                 mcb_vld_i,
    input  logic [MCB_DBITS-1:0] mcb_dat_i,
    output logic [AXNUM-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [2:0]           state_o
);

    localparam int MSB = AXNUM - 1;
    localparam int ASB = ABITS - 1;
    localparam int CW  = FBITS + 2;

    rb_state_t      state;
    logic           enable_q;
    logic [ASB:0]   len_q;
    logic [ASB:0]   adr_inc;
    logic [FBITS:0] outst;
    logic [FBITS:0] outst_next;
    logic [FBITS:0] fifo_count;
    logic [CW-1:0]  credit_next;
    logic           fifo_empty;
    logic           fifo_full;
    logic           accept;
    logic           ret;
    logic           pop;
    logic           push;
    logic           flush;
    logic           abort_now;
    logic           room;
    logic           unused_bits;

    assign accept    = mcb_ce_o && mcb_rdy_i;
    assign ret       = mcb_vld_i && (outst != '0);
    assign pop       = !fifo_empty && ready_i;
    assign abort_now = !enable_i && (state == ST_FETCH || state == ST_DRAIN);
    // Flushing on the abort edge itself keeps valid_o low for the whole ABORT stay.
    assign flush     = abort_now || (state == ST_ABORT);
    assign push      = ret && !flush;
    assign adr_inc   = mcb_adr_o + ABITS'(1);

    // Credits after this edge: every word either buffered or still in flight counts against the FIFO depth.
    assign credit_next = CW'(fifo_count) + CW'(outst) + CW'(accept) - CW'(pop);
    assign room        = credit_next < CW'(2**FBITS);

    always_comb begin
        outst_next = outst;
        if (accept && !ret) begin
            outst_next = outst + (FBITS+1)'(1);
        end else if (ret && !accept) begin
            outst_next = outst - (FBITS+1)'(1);
        end
    end

    assign mcb_wr_o    = 1'b0;
    assign valid_o     = !fifo_empty;
    assign busy_o      = (state == ST_FETCH) || (state == ST_DRAIN) || (state == ST_ABORT);
    assign done_o      = (state == ST_DONE);
    assign state_o     = state;
    assign unused_bits = ^mcb_dat_i[MCB_DBITS-1:AXNUM];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= ST_IDLE;
            enable_q  <= 1'b0;
            len_q     <= '0;
            mcb_adr_o <= '0;
            mcb_ce_o  <= 1'b0;
            outst     <= '0;
            error_o   <= 1'b0;
        end else begin
            enable_q <= enable_i;
            outst    <= outst_next;
            if (mcb_vld_i && outst == '0) begin
                error_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable_i && !enable_q) begin
                        if (length_i != '0) begin
                            len_q     <= length_i;
                            mcb_adr_o <= '0;
                            mcb_ce_o  <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!enable_i) begin
                        mcb_ce_o <= 1'b0;
                        state    <= ST_ABORT;
                    end else if (accept) begin
                        mcb_adr_o <= adr_inc;
                        if (adr_inc == len_q) begin
                            mcb_ce_o <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            mcb_ce_o <= room;
                        end
                    end else if (!mcb_ce_o) begin
                        mcb_ce_o <= room;
                    end
                end
                ST_DRAIN: begin
                    if (!enable_i) begin
                        state <= ST_ABORT;
                    end else if (outst == '0 && fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (outst == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    readback_fifo #(
        .WIDTH(AXNUM),
        .FBITS(FBITS)
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .flush    (flush),
        .push     (push),
        .push_data(mcb_dat_i[MSB:0]),
        .pop      (pop),
        .data     (data_o),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    logic unused_full;
    assign unused_full = fifo_full ^ len_q[ASB];

endmodule
